// File: rtl/router_pkg.sv
// Shared router definitions: framing state encoding, size-field mask,
// packet header/trailer byte counts and the trusted-source IDs used by
// the receiver. No ports; imported by the per-port buffer logic.
package router_pkg;

  // Position of the head byte within the current packet.
  typedef enum logic [2:0] {
    FR_SRC  = 3'd0,
    FR_DST  = 3'd1,
    FR_SIZE = 3'd2,
    FR_DATA = 3'd3,
    FR_CRC  = 3'd4
  } frame_state_e;

  // Only the low three bits of the size byte carry the data length.
  localparam logic [2:0] SIZE_MASK = 3'b111;

  localparam int HDR_BYTES = 3;
  localparam int CRC_BYTES = 1;

  // Source IDs the receiver accepts without further checks.
  localparam logic [7:0] TS1 = 8'h01;
  localparam logic [7:0] TS2 = 8'h02;
  localparam logic [7:0] TS3 = 8'h03;

  // Total bytes in a packet given its size byte (5..12).
  function automatic logic [3:0] pkt_total_bytes(input logic [7:0] size_byte);
    return {1'b0, size_byte[2:0] & SIZE_MASK} + 4'(HDR_BYTES + CRC_BYTES + 1);
  endfunction

endpackage

// File: rtl/pkt_frame_tracker.sv
// Read-side framing tracker. Follows the popped byte stream through
// SRC/DST/SIZE/DATA/CRC, accumulating an XOR checksum over every byte
// before the CRC byte.
// Ports:
//   clk1, rst        clock, async active-low reset
//   pop              accepted pop of the head byte
//   dout, dout_valid head byte and its valid flag
//   sop, eop         head byte is first / last byte of its packet
//   crc_err          one-cycle pulse after popping a CRC byte that mismatched
module pkt_frame_tracker
  import router_pkg::*;
(
  input  logic       clk1,
  input  logic       rst,
  input  logic       pop,
  input  logic [7:0] dout,
  input  logic       dout_valid,
  output logic       sop,
  output logic       eop,
  output logic       crc_err
);

  frame_state_e state_q, state_d;
  logic [2:0]   k_q, k_d;
  logic [7:0]   chk_q, chk_d;
  logic         crc_err_q, crc_err_d;

  // Next framing state, remaining-data counter and running checksum.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    chk_d     = chk_q;
    crc_err_d = 1'b0;
    if (pop) begin
      case (state_q)
        FR_SRC: begin
          chk_d   = dout;
          state_d = FR_DST;
        end
        FR_DST: begin
          chk_d   = chk_q ^ dout;
          state_d = FR_SIZE;
        end
        FR_SIZE: begin
          chk_d   = chk_q ^ dout;
          k_d     = dout[2:0] & SIZE_MASK;
          state_d = FR_DATA;
        end
        FR_DATA: begin
          chk_d = chk_q ^ dout;
          if (k_q == 3'd0) begin
            state_d = FR_CRC;
          end else begin
            k_d = k_q - 3'd1;
          end
        end
        FR_CRC: begin
          crc_err_d = (dout != chk_q);
          state_d   = FR_SRC;
        end
        default: begin
          state_d = FR_SRC;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Framing registers.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state_q   <= FR_SRC;
      k_q       <= 3'd0;
      chk_q     <= 8'h00;
      crc_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      chk_q     <= chk_d;
      crc_err_q <= crc_err_d;
    end
  end

  // sop stays high while idle so the tracker's position is visible even
  // with nothing buffered; eop only marks a real head byte.
  assign sop     = (state_q == FR_SRC);
  assign eop     = (state_q == FR_CRC) && dout_valid;
  assign crc_err = crc_err_q;

endmodule

// File: rtl/port_packet_fifo.sv
// Per-output-port packet buffer: single-clock FIFO with first-word-fall-through
// read side plus a packet framing tracker on the popped stream.
// Ports:
//   clk1, rst            clock, async active-low reset
//   winc, wdata, wfull   write side from the packet receiver
//   rd_en                pop strobe from the port transmitter
//   dout, dout_valid     head byte (zero read latency) and non-empty flag
//   sop, eop, crc_err    framing markers / checksum error pulse
//   overflow             sticky: a write was attempted while full
//   fill                 current occupancy 0..DEPTH
module port_packet_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          winc,
  input  logic [7:0]    wdata,
  output logic          wfull,
  input  logic          rd_en,
  output logic [7:0]    dout,
  output logic          dout_valid,
  output logic          sop,
  output logic          eop,
  output logic          crc_err,
  output logic          overflow,
  output logic [AW:0]   fill
);

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full_s, wr_ok_s, rd_ok_s;

  assign full_s  = (count_q == FULL_CNT);
  assign wr_ok_s = winc && !full_s;
  assign rd_ok_s = rd_en && (count_q != '0);

  // Next storage, pointer, occupancy and overflow values.
  always_comb begin
    mem_d = mem_q;
    if (wr_ok_s) begin
      mem_d[wp_q] = wdata;
      wp_d        = wp_q + PTR_ONE;
    end else begin
      wp_d = wp_q;
    end
    if (rd_ok_s) begin
      rp_d = rp_q + PTR_ONE;
    end else begin
      rp_d = rp_q;
    end
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q | (winc && full_s);
  end

  // FIFO state registers; the array is cleared so dout reads 0 after reset.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign dout       = mem_q[rp_q];
  assign dout_valid = (count_q != '0);
  assign wfull      = full_s;
  assign fill       = count_q;
  assign overflow   = overflow_q;

  pkt_frame_tracker u_tracker (
    .clk1       (clk1),
    .rst        (rst),
    .pop        (rd_ok_s),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sop        (sop),
    .eop        (eop),
    .crc_err    (crc_err)
  );

endmodule

// File: tb/tb_port_packet_fifo.sv
module tb_port_packet_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk1 = 1'b0;
  logic        rst = 1'b0;
  logic        winc = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic        wfull, dout_valid, sop, eop, crc_err, overflow;
  logic [7:0]  dout;
  logic [AW:0] fill;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] data;
    bit         first;
    bit         last;
    bit         corrupt;
  } ent_t;

  ent_t mq[$];
  ent_t src[$];

  port_packet_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk1(clk1), .rst(rst), .winc(winc), .wdata(wdata), .wfull(wfull),
    .rd_en(rd_en), .dout(dout), .dout_valid(dout_valid), .sop(sop),
    .eop(eop), .crc_err(crc_err), .overflow(overflow), .fill(fill)
  );

  always #5 clk1 = ~clk1;

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    winc = w; wdata = d; rd_en = r;
    @(posedge clk1); #1;
    winc = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; #3; rst = 1'b1;
    @(posedge clk1); #1;
  endtask

  // Builds one packet: src, dst, size, data bytes, XOR checksum byte.
  task automatic gen_packet(input bit corrupt);
    logic [7:0] b[$];
    logic [7:0] chk;
    logic [7:0] size;
    int n;
    size = 8'($urandom);
    n = int'(size[2:0]) + 1;
    b.push_back(8'($urandom));
    b.push_back(8'($urandom));
    b.push_back(size);
    for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    chk = 8'h00;
    foreach (b[i]) chk = chk ^ b[i];
    if (corrupt) chk = chk ^ 8'($urandom_range(1, 255));
    b.push_back(chk);
    foreach (b[i]) begin
      ent_t e;
      e.data = b[i]; e.first = (i == 0); e.last = (i == b.size() - 1);
      e.corrupt = corrupt;
      src.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk1); #1;
    total++;
    if ({fill, dout_valid, wfull, dout} !== {5'd0, 1'b0, 1'b0, 8'h00}) begin
      bad++; $display("FAIL reset_fifo: got fill=%0d valid=%b full=%b dout=%h want 0/0/0/00",
                      fill, dout_valid, wfull, dout);
    end
    total++;
    if ({sop, eop, crc_err, overflow} !== 4'b1000) begin
      bad++; $display("FAIL reset_flags: got sop/eop/crc/ovf=%b%b%b%b want 1000", sop, eop, crc_err, overflow);
    end
    rst = 1'b1;
    @(posedge clk1); #1;
  endtask

  task automatic run_packet(input logic [7:0] p[5], input bit exp_err, input string nm);
    for (int i = 0; i < 5; i++) step(1'b1, p[i], 1'b0);
    total++;
    if (fill !== 5'd5) begin bad++; $display("FAIL %s_fill: got %0d want 5", nm, fill); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({dout_valid, dout, sop, eop} !== {1'b1, p[i], i == 0, i == 4}) begin
        bad++; $display("FAIL %s_byte%0d: got valid=%b dout=%h sop=%b eop=%b want 1 %h %b %b",
                        nm, i, dout_valid, dout, sop, eop, p[i], i == 0, i == 4);
      end
      step(1'b0, 8'h00, 1'b1);
    end
    total++;
    if (crc_err !== exp_err) begin bad++; $display("FAIL %s_crc: got %b want %b", nm, crc_err, exp_err); end
    total++;
    if (fill !== 5'd0) begin bad++; $display("FAIL %s_drain: got fill=%0d want 0", nm, fill); end
  endtask

  task automatic test_good_packet();
    logic [7:0] p[5] = '{8'h00, 8'h05, 8'h00, 8'hAA, 8'hAF};
    run_packet(p, 1'b0, "good");
  endtask

  task automatic test_bad_crc();
    logic [7:0] p[5] = '{8'h00, 8'h05, 8'h00, 8'hAA, 8'h00};
    logic [7:0] g[5] = '{8'h00, 8'h05, 8'h00, 8'hAA, 8'hAF};
    run_packet(p, 1'b1, "badcrc");
    step(1'b1, g[0], 1'b0);
    total++;
    if (crc_err !== 1'b0) begin bad++; $display("FAIL badcrc_pulse_width: got %b want 0", crc_err); end
    total++;
    if ({dout_valid, sop, dout} !== {1'b1, 1'b1, g[0]}) begin
      bad++; $display("FAIL badcrc_next_sop: got valid=%b sop=%b dout=%h want 1 1 %h", dout_valid, sop, dout, g[0]);
    end
    step(1'b0, 8'h00, 1'b1);
    do_reset();
  endtask

  task automatic test_fill_overflow();
    logic [7:0] v[16];
    foreach (v[i]) begin v[i] = 8'($urandom); step(1'b1, v[i], 1'b0); end
    total++;
    if ({wfull, fill, overflow} !== {1'b1, 5'd16, 1'b0}) begin
      bad++; $display("FAIL full_status: got full=%b fill=%0d ovf=%b want 1 16 0", wfull, fill, overflow);
    end
    step(1'b1, 8'h5A, 1'b0);
    total++;
    if ({overflow, fill} !== {1'b1, 5'd16}) begin
      bad++; $display("FAIL overflow_set: got ovf=%b fill=%0d want 1 16", overflow, fill);
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (dout !== v[i]) begin bad++; $display("FAIL full_order%0d: got %h want %h", i, dout, v[i]); end
      step(1'b0, 8'h00, 1'b1);
    end
    total++;
    if ({fill, dout_valid, overflow} !== {5'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL full_drain: got fill=%0d valid=%b ovf=%b want 0 0 1", fill, dout_valid, overflow);
    end
    step(1'b0, 8'h00, 1'b1);
    total++;
    if (fill !== 5'd0) begin bad++; $display("FAIL empty_pop: got fill=%0d want 0", fill); end
    do_reset();
  endtask

  task automatic test_full_rw();
    logic [7:0] v[16];
    foreach (v[i]) begin v[i] = 8'($urandom); step(1'b1, v[i], 1'b0); end
    step(1'b1, 8'hC3, 1'b1);
    total++;
    if ({fill, overflow} !== {5'd15, 1'b1}) begin
      bad++; $display("FAIL full_rw: got fill=%0d ovf=%b want 15 1", fill, overflow);
    end
    for (int i = 1; i < 16; i++) begin
      total++;
      if (dout !== v[i]) begin bad++; $display("FAIL full_rw_order%0d: got %h want %h", i, dout, v[i]); end
      step(1'b0, 8'h00, 1'b1);
    end
    total++;
    if (fill !== 5'd0) begin bad++; $display("FAIL full_rw_drain: got fill=%0d want 0", fill); end
    do_reset();
  endtask

  task automatic test_empty_rw();
    step(1'b1, 8'h3C, 1'b1);
    total++;
    if ({fill, dout_valid, dout} !== {5'd1, 1'b1, 8'h3C}) begin
      bad++; $display("FAIL empty_rw: got fill=%0d valid=%b dout=%h want 1 1 3c", fill, dout_valid, dout);
    end
    do_reset();
  endtask

  task automatic test_mid_reset();
    logic [7:0] p[12];
    logic [7:0] g[5] = '{8'h01, 8'h02, 8'h00, 8'h10, 8'h13};
    logic [7:0] chk = 8'h00;
    p[0] = 8'h01; p[1] = 8'h02; p[2] = 8'h07;
    for (int i = 3; i < 11; i++) p[i] = 8'($urandom);
    for (int i = 0; i < 11; i++) chk = chk ^ p[i];
    p[11] = chk;
    foreach (p[i]) step(1'b1, p[i], 1'b0);
    total++;
    if (fill !== 5'd12) begin bad++; $display("FAIL mid_fill: got %0d want 12", fill); end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    rst = 1'b0;
    #2;
    total++;
    if ({fill, dout_valid, sop, dout} !== {5'd0, 1'b0, 1'b1, 8'h00}) begin
      bad++; $display("FAIL mid_reset: got fill=%0d valid=%b sop=%b dout=%h want 0 0 1 00",
                      fill, dout_valid, sop, dout);
    end
    #2 rst = 1'b1;
    @(posedge clk1); #1;
    run_packet(g, 1'b0, "post_reset");
  endtask

  task automatic test_random();
    bit exp_crc = 1'b0;
    bit exp_crc_n;
    logic w, r;
    logic [7:0] d;
    mq.delete(); src.delete();
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (src.size() == 0) gen_packet($urandom_range(0, 3) == 0);
      total++;
      if ({fill, dout_valid, wfull, overflow, crc_err} !==
          {5'(mq.size()), mq.size() != 0, mq.size() == DEPTH, 1'b0, exp_crc}) begin
        bad++; $display("FAIL rand_status@%0d: got fill=%0d valid=%b full=%b ovf=%b crc=%b want %0d %b %b 0 %b",
                        cyc, fill, dout_valid, wfull, overflow, crc_err,
                        mq.size(), mq.size() != 0, mq.size() == DEPTH, exp_crc);
      end
      if (mq.size() != 0) begin
        total++;
        if ({dout, sop, eop} !== {mq[0].data, mq[0].first, mq[0].last}) begin
          bad++; $display("FAIL rand_head@%0d: got dout=%h sop=%b eop=%b want %h %b %b",
                          cyc, dout, sop, eop, mq[0].data, mq[0].first, mq[0].last);
        end
      end
      w = (mq.size() < DEPTH) && ((cyc % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      r = (cyc % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      d = w ? src[0].data : 8'($urandom);
      exp_crc_n = 1'b0;
      if (r && mq.size() != 0) begin
        ent_t e;
        e = mq.pop_front();
        exp_crc_n = e.last && e.corrupt;
      end
      if (w) mq.push_back(src.pop_front());
      step(w, d, r);
      exp_crc = exp_crc_n;
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_crc();
    test_fill_overflow();
    test_full_rw();
    test_empty_rw();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
